// File: rtl/cpu_nn_pkg.sv
// Shared CPU_NN definitions for the writeback path.
//   WB_ADDR_WIDTH / WB_DATA_WIDTH : register-file write port geometry
//   SRC_REQ0 / SRC_REQ1           : requester encoding used for sel, grant and out_src
//   wb_state_e                    : output-stage occupancy (EMPTY / FULL)
package cpu_nn_pkg;

  localparam int WB_ADDR_WIDTH = 6;
  localparam int WB_DATA_WIDTH = 32;

  localparam logic SRC_REQ0 = 1'b0;  // ALU / load path
  localparam logic SRC_REQ1 = 1'b1;  // neuron / multiply unit

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/mux32x2_6bits.sv
// Two-input multiplexer used on the writeback address and data paths.
//   i_in0 / i_in1 : candidate values
//   i_sel         : 0 picks i_in0, 1 picks i_in1
//   o_out         : selected value
// WIDTH defaults to the 6-bit register address; the data path instantiates
// it at the full data width.
module mux32x2_6bits #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] i_in0,
  input  logic [WIDTH-1:0] i_in1,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_out
);

  assign o_out = i_sel ? i_in1 : i_in0;

endmodule

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a last-grant register.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_req0, i_req1   : request lines
//   i_accept         : the current grant was taken this cycle
//   o_grant_valid    : at least one request is present
//   o_grant          : winning requester (meaningful only with o_grant_valid)
//   o_sel            : mux select; follows o_grant, holds last grant when idle
module rr_arb2
  import cpu_nn_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_accept,
  output logic o_grant_valid,
  output logic o_grant,
  output logic o_sel
);

  // Reset to requester 1 so requester 0 wins the first contention.
  logic r_last_grant;

  always_comb begin
    o_grant_valid = i_req0 | i_req1;
    o_grant       = SRC_REQ0;
    if (i_req0 && i_req1) begin
      o_grant = ~r_last_grant;
    end else if (i_req1) begin
      o_grant = SRC_REQ1;
    end
    o_sel = o_grant_valid ? o_grant : r_last_grant;
  end

  // Priority only rotates on an actual transfer, never on idle cycles.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_last_grant <= SRC_REQ1;
    end else if (i_accept) begin
      r_last_grant <= o_grant;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the ALU/load path (requester 0) and the neuron/multiply unit
// (requester 1) onto the single register-file write port.
//   clk, reset_n                      : clock, asynchronous active-low reset
//   req0_valid/addr/data, req0_ready  : requester 0 write channel
//   req1_valid/addr/data, req1_ready  : requester 1 write channel
//   sel                               : combinational mux select (0 = req0)
//   out_valid/addr/data/src, out_ready: registered write toward register file
//   dbg_state                         : output-stage occupancy (EMPTY / FULL)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Ready may depend on valid; valid never depends on ready. A
// requester holds valid and its payload stable until it sees ready. At most
// one requester is ready in any cycle. Downstream, out_* are held stable
// while out_valid is high and out_ready is low.
//
// Writes to register 0 are accepted (consumed) but never reach the output.
module wb_port_arbiter
  import cpu_nn_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  sel,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_src,
  input  logic                  out_ready,
  output wb_state_e             dbg_state
);

  wb_state_e             r_state;
  wb_state_e             w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_src;

  logic                  w_grant_valid;
  logic                  w_grant;
  logic                  w_sel;
  logic                  w_free;
  logic                  w_accept;
  logic                  w_write;
  logic [ADDR_WIDTH-1:0] w_mux_addr;
  logic [DATA_WIDTH-1:0] w_mux_data;

  // The output slot can take a new entry when empty, or when the current
  // entry is leaving this same cycle.
  assign w_free   = (r_state == WB_EMPTY) | out_ready;
  assign w_accept = w_free & w_grant_valid;
  // Register 0 is hard-wired: the write is consumed but not forwarded.
  assign w_write  = w_accept & (w_mux_addr != '0);

  rr_arb2 u_arb (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_req0        (req0_valid),
    .i_req1        (req1_valid),
    .i_accept      (w_accept),
    .o_grant_valid (w_grant_valid),
    .o_grant       (w_grant),
    .o_sel         (w_sel)
  );

  mux32x2_6bits #(.WIDTH(ADDR_WIDTH)) u_addr_mux (
    .i_in0 (req0_addr),
    .i_in1 (req1_addr),
    .i_sel (w_sel),
    .o_out (w_mux_addr)
  );

  mux32x2_6bits #(.WIDTH(DATA_WIDTH)) u_data_mux (
    .i_in0 (req0_data),
    .i_in1 (req1_data),
    .i_sel (w_sel),
    .o_out (w_mux_data)
  );

  assign req0_ready = w_accept & (w_grant == SRC_REQ0);
  assign req1_ready = w_accept & (w_grant == SRC_REQ1);
  assign sel        = w_sel;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WB_EMPTY: begin
        if (w_write) w_state_nxt = WB_FULL;
      end
      WB_FULL: begin
        // A replacing write keeps the slot full for back-to-back throughput.
        if (out_ready) w_state_nxt = w_write ? WB_FULL : WB_EMPTY;
      end
      default: w_state_nxt = WB_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= WB_EMPTY;
      r_addr  <= '0;
      r_data  <= '0;
      r_src   <= SRC_REQ0;
    end else begin
      r_state <= w_state_nxt;
      if (w_write) begin
        r_addr <= w_mux_addr;
        r_data <= w_mux_data;
        r_src  <= w_grant;
      end
    end
  end

  assign out_valid = (r_state == WB_FULL);
  assign out_addr  = r_addr;
  assign out_data  = r_data;
  assign out_src   = r_src;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  import cpu_nn_pkg::*;

  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;

  logic          clk;
  logic          reset_n;
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          sel;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic          out_ready;
  wb_state_e     dbg_state;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  wb_port_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .sel        (sel),
    .out_valid  (out_valid),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .dbg_state  (dbg_state)
  );

  // ---------------- invariant monitor (mid-cycle) ----------------
  logic          mon_en = 1'b0;
  logic          prev_hold = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;
  logic          prev_src;

  always @(negedge clk) begin
    if (mon_en && reset_n === 1'b1) begin
      checks++;
      if ((req0_ready & req1_ready) !== 1'b0) begin
        errors++;
        $display("FAIL mon_one_ready: got r0=%b r1=%b required not both", req0_ready, req1_ready);
      end
      checks++;
      if ((out_valid && out_addr == '0) !== 1'b0) begin
        errors++;
        $display("FAIL mon_no_r0_write: got valid=%b addr=%0d required no write to 0", out_valid, out_addr);
      end
      if (prev_hold) begin
        checks++;
        if ({out_valid, out_addr, out_data, out_src} !== {1'b1, prev_addr, prev_data, prev_src}) begin
          errors++;
          $display("FAIL mon_stall_stable: got v=%b a=%0d d=%h s=%b required v=1 a=%0d d=%h s=%b",
                   out_valid, out_addr, out_data, out_src, prev_addr, prev_data, prev_src);
        end
      end
      prev_hold = out_valid & ~out_ready;
      prev_addr = out_addr;
      prev_data = out_data;
      prev_src  = out_src;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n   = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 6'd5, 32'hAAAA_0000, 1'b1, 6'd7, 32'h0000_BBBB);
    #12;
    checks++;
    if ({out_valid, out_addr, out_data, out_src} !== {1'b0, 6'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b a=%0d d=%h s=%b required all zero",
               out_valid, out_addr, out_data, out_src);
    end
    checks++;
    if (dbg_state !== WB_EMPTY) begin
      errors++;
      $display("FAIL reset_state: got %0d required %0d", dbg_state, WB_EMPTY);
    end
    @(negedge clk);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;
    checks++;
    if ({req0_ready, req1_ready, sel} !== 3'b100) begin
      errors++;
      $display("FAIL first_grant: got r0=%b r1=%b sel=%b required r0=1 r1=0 sel=0", req0_ready, req1_ready, sel);
    end
    step();
    checks++;
    if ({out_valid, out_addr, out_data, out_src} !== {1'b1, 6'd5, 32'hAAAA_0000, 1'b0}) begin
      errors++;
      $display("FAIL first_out: got v=%b a=%0d d=%h s=%b required v=1 a=5 d=aaaa0000 s=0",
               out_valid, out_addr, out_data, out_src);
    end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          es;
    // Requester 0 was just served, so the stream continues 7,5,7,5,7.
    for (int i = 0; i < 5; i++) begin
      es = (i % 2 == 0) ? 1'b1 : 1'b0;
      ea = es ? 6'd7 : 6'd5;
      ed = es ? 32'h0000_BBBB : 32'hAAAA_0000;
      step();
      checks++;
      if ({out_valid, out_addr, out_data, out_src} !== {1'b1, ea, ed, es}) begin
        errors++;
        $display("FAIL rr_cycle%0d: got v=%b a=%0d d=%h s=%b required v=1 a=%0d d=%h s=%b",
                 i, out_valid, out_addr, out_data, out_src, ea, ed, es);
      end
    end
  endtask

  task automatic test_zero_reg();
    drive(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got out_valid=%b required 0", out_valid);
    end
    drive(1'b1, 6'd0, 32'h1234_5678, 1'b0, 6'd0, 32'd0);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL zero_ready: got r0=%b r1=%b required r0=1 r1=0", req0_ready, req1_ready);
    end
    step();
    drive(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    checks++;
    if ({out_valid, dbg_state} !== {1'b0, WB_EMPTY}) begin
      errors++;
      $display("FAIL zero_dropped: got v=%b st=%0d required v=0 st=0", out_valid, dbg_state);
    end
    // The register-0 write still counts as a grant to requester 0.
    drive(1'b1, 6'd5, 32'hAAAA_0000, 1'b1, 6'd7, 32'h0000_BBBB);
    #1;
    checks++;
    if ({req0_ready, req1_ready, sel} !== 3'b011) begin
      errors++;
      $display("FAIL zero_then_rr: got r0=%b r1=%b sel=%b required r0=0 r1=1 sel=1", req0_ready, req1_ready, sel);
    end
    step();
    checks++;
    if ({out_valid, out_addr, out_src} !== {1'b1, 6'd7, 1'b1}) begin
      errors++;
      $display("FAIL zero_then_out: got v=%b a=%0d s=%b required v=1 a=7 s=1", out_valid, out_addr, out_src);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 6'd9, 32'h0000_0099, 1'b0, 6'd0, 32'd0);
    step();
    checks++;
    if ({out_valid, out_addr, out_data, out_src} !== {1'b1, 6'd9, 32'h99, 1'b0}) begin
      errors++;
      $display("FAIL bp_load: got v=%b a=%0d d=%h s=%b required v=1 a=9 d=99 s=0",
               out_valid, out_addr, out_data, out_src);
    end
    out_ready = 1'b0;
    drive(1'b1, 6'd5, 32'hAAAA_0000, 1'b1, 6'd7, 32'h0000_BBBB);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        errors++;
        $display("FAIL bp_ready%0d: got r0=%b r1=%b required both 0", i, req0_ready, req1_ready);
      end
      step();
      checks++;
      if ({out_valid, out_addr, out_data, out_src} !== {1'b1, 6'd9, 32'h99, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b a=%0d d=%h s=%b required v=1 a=9 d=99 s=0",
                 i, out_valid, out_addr, out_data, out_src);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release_ready: got r0=%b r1=%b required r0=0 r1=1", req0_ready, req1_ready);
    end
    step();
    checks++;
    if ({out_valid, out_addr, out_data, out_src} !== {1'b1, 6'd7, 32'h0000_BBBB, 1'b1}) begin
      errors++;
      $display("FAIL bp_release_out: got v=%b a=%0d d=%h s=%b required v=1 a=7 d=0000bbbb s=1",
               out_valid, out_addr, out_data, out_src);
    end
  endtask

  task automatic test_same_addr();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rf12;
    // Last grant went to requester 1, so requester 0 lands first.
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h2);
    drive(1'b1, 6'd12, 32'h1, 1'b1, 6'd12, 32'h2);
    rf12 = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      logic [DW-1:0] ed;
      ed = exp_q.pop_front();
      step();
      if (i == 1) drive(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
      checks++;
      if ({out_valid, out_addr, out_data, out_src} !== {1'b1, 6'd12, ed, i[0]}) begin
        errors++;
        $display("FAIL same_addr%0d: got v=%b a=%0d d=%h s=%b required v=1 a=12 d=%h s=%b",
                 i, out_valid, out_addr, out_data, out_src, ed, i[0]);
      end
      if (out_valid && out_ready && out_addr == 6'd12) rf12 = out_data;
    end
    checks++;
    if (rf12 !== 32'h2) begin
      errors++;
      $display("FAIL same_addr_final: got %h required 00000002", rf12);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL same_addr_drain: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 6'd5, 32'hAAAA_0000, 1'b0, 6'd0, 32'd0);
    step();
    checks++;
    if ({out_valid, out_addr, out_src} !== {1'b1, 6'd5, 1'b0}) begin
      errors++;
      $display("FAIL ar_pre: got v=%b a=%0d s=%b required v=1 a=5 s=0", out_valid, out_addr, out_src);
    end
    // Requester 0 was just served; without reset requester 1 would win next.
    drive(1'b1, 6'd5, 32'hAAAA_0000, 1'b1, 6'd7, 32'h0000_BBBB);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_addr, out_data, dbg_state} !== {1'b0, 6'd0, 32'd0, WB_EMPTY}) begin
      errors++;
      $display("FAIL ar_drop: got v=%b a=%0d d=%h st=%0d required all zero",
               out_valid, out_addr, out_data, dbg_state);
    end
    @(negedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL ar_priority: got r0=%b r1=%b required r0=1 r1=0", req0_ready, req1_ready);
    end
    step();
    checks++;
    if ({out_valid, out_addr, out_src} !== {1'b1, 6'd5, 1'b0}) begin
      errors++;
      $display("FAIL ar_post: got v=%b a=%0d s=%b required v=1 a=5 s=0", out_valid, out_addr, out_src);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_round_robin();
    test_zero_reg();
    test_backpressure();
    test_same_addr();
    test_async_reset();
    drive(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    step();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates two writeback requesters for the single register-file write port of the CPU_NN core:
  - requester 0 is the ALU/load path;
  - requester 1 is the neuron/multiply unit.
- Drives the select of the 2:1 address/data multiplexers and registers the winner into a one-entry output stage with valid/ready handshake toward the register file.
- Round-robin fairness.
- Writes to register 0 are discarded.

Parameters:
- ADDR_WIDTH, 6, register address width.
- DATA_WIDTH, 32, writeback data width.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has a write pending
- req0_addr  input  ADDR_WIDTH  requester 0 destination register
- req0_data  input  DATA_WIDTH  requester 0 write data
- req0_ready  output  1  requester 0 accepted this cycle
- req1_valid  input  1  requester 1 has a write pending
- req1_addr  input  ADDR_WIDTH  requester 1 destination register
- req1_data  input  DATA_WIDTH  requester 1 write data
- req1_ready  output  1  requester 1 accepted this cycle
- sel  output  1  mux select, 0 = requester 0, 1 = requester 1 (combinational)
- out_valid  output  1  registered write valid to register file
- out_addr  output  ADDR_WIDTH  registered write address
- out_data  output  DATA_WIDTH  registered write data
- out_src  output  1  source of the registered write
- out_ready  input  1  register file accepts the write

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous assert, synchronous deassert (externally synchronised), active-low.
- Reset values:
  - out_valid=0, out_addr=0, out_data=0, out_src=0.
  - last_grant=1, so requester 0 wins the first contention.
- Slot free: free = !out_valid | out_ready.
- Grant (combinational):
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant !last_grant.
  - Neither valid: no grant; sel holds last_grant.
- Ready:
  - reqN_ready = free & grant==N.
  - At most one ready per cycle.
  - Ready depends on valid; valid must never depend on ready.
- Accept: reqN_valid & reqN_ready. On accept, last_grant <= N. Update only on accept, never on idle cycles.
- Output stage (states EMPTY/FULL, encoded by out_valid):
  - EMPTY + accept with addr!=0 -> FULL; latch addr, data, src. Latency one cycle from accept to out_valid.
  - FULL + out_ready + accept with addr!=0 -> FULL; new entry replaces old. Full throughput, one write per cycle.
  - FULL + out_ready + no accept (or addr==0 accept) -> EMPTY.
  - FULL + !out_ready -> hold all out_* stable; no ready asserted.
- Zero register:
  - An accepted request with addr==0 is consumed (ready=1) but produces no output.
  - last_grant still updates.
- Same-address contention: both requesters targeting the same register are serialised in grant order, with no merging. The loser's write lands one cycle later and overwrites.
- Out-of-range widths: none; addr and data pass through unmodified.
- Reset mid-operation: any pending output entry is dropped immediately; requesters must re-present after reset.
- Assertions for the bench:
  - never req0_ready & req1_ready;
  - out_* stable while out_valid & !out_ready;
  - no out_valid with out_addr==0.

Decomposition:
- Shared package cpu_nn_pkg:
  - WB_ADDR_WIDTH=6, WB_DATA_WIDTH=32;
  - SRC_REQ0=1'b0, SRC_REQ1=1'b1.
- Sub-module rr_arb2: two-requester round-robin grant with the last_grant register, outputs grant and sel.
- Datapath muxing uses the existing mux32x2_6bits for the address and a DATA_WIDTH-parameterised instance of the same module for data, both driven by sel.
- Output register stays in wb_port_arbiter.

Test Plan:
1. Reset with both valid held high, release reset_n -> first accept is requester 0 (req0_ready=1, req1_ready=0); out_valid=1 next cycle with out_src=0.
2. Both valid continuously, out_ready=1, req0 addr=5 data=0xAAAA0000, req1 addr=7 data=0x0000BBBB -> out_addr alternates 5,7,5,7 every cycle with matching data and src; no bubbles.
3. req0 addr=0 data=0x12345678 alone -> req0_ready=1 for one cycle, out_valid stays 0; next contention grants requester 1.
4. Output FULL (addr=9), out_ready=0 for 4 cycles with both requesters valid -> out_* frozen at addr 9, both readies 0; on out_ready=1 the pending winner is accepted in that same cycle.
5. Both requesters target addr=12 (data 0x1 and 0x2) -> two sequential writes to 12 in grant order, final register value from the later grant.
6. Assert reset_n=0 asynchronously mid-cycle while out_valid=1 -> out_valid drops immediately (before the next clk edge); after release, requester 0 has priority again.
